// File: rtl/seg7_scan_ctrl.sv
// Round-robin scan of NDIG common-anode 7-segment digits with blanking gaps and frame-atomic updates.
// Latency: pins lag the scan FSM by 1 clk; a load is shown from the next frame boundary.
// Backpressure: none; load is a strobe, and a second load before commit overwrites the shadow.
module seg7_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_data,
  input  logic [NDIG-1:0]   dp_in,
  input  logic [NDIG-1:0]   blank_mask,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              pending,
  output logic              frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_END  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_DIG  = IW'(NDIG - 1);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic              boundary;
  logic              fd_nxt;

  logic [4*NDIG-1:0] disp_dat, shadow_dat;
  logic [NDIG-1:0]   disp_dp, shadow_dp;

  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_mask;
  logic [NDIG-1:0]   an_nxt;
  logic [6:0]        seg_nxt;
  logic              dp_nxt;

  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    boundary  = 1'b0;
    case (state)
      S_BLANK: begin
        if (cnt == BLANK_END) state_nxt = S_DRIVE;
      end
      default: begin
        if (cnt == SLOT_END) begin
          cnt_nxt   = '0;
          state_nxt = S_BLANK;
          if (idx == LAST_DIG) begin
            idx_nxt  = '0;
            boundary = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
    endcase
    // Registered so the pulse covers the cycle whose closing edge commits the frame
    fd_nxt = (state_nxt == S_DRIVE) && (cnt_nxt == SLOT_END) && (idx_nxt == LAST_DIG);
  end

  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_mask = 1'b0;
    an_nxt   = '1;
    for (int k = 0; k < NDIG; k++) begin
      if (idx == IW'(k)) begin
        cur_nib  = disp_dat[4*k +: 4];
        cur_dp   = disp_dp[k];
        cur_mask = blank_mask[k];
      end
    end
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (state == S_DRIVE) begin
      seg_nxt = decode(cur_nib);
      dp_nxt  = ~cur_dp;
      for (int k = 0; k < NDIG; k++) begin
        if (idx == IW'(k) && !cur_mask) an_nxt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_BLANK;
      cnt        <= '0;
      idx        <= '0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= fd_nxt;
    end
  end

  // A load landing on the boundary bypasses the shadow so it is not held a whole extra frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_dat   <= '0;
      disp_dp    <= '0;
      shadow_dat <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else if (load) begin
      shadow_dat <= load_data;
      shadow_dp  <= dp_in;
      if (boundary) begin
        disp_dat <= load_data;
        disp_dp  <= dp_in;
        pending  <= 1'b0;
      end else begin
        pending <= 1'b1;
      end
    end else if (boundary && pending) begin
      disp_dat <= shadow_dat;
      disp_dp  <= shadow_dp;
      pending  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: position-in-frame reference model checked every cycle, plus directed literal checks.
module tb_seg7_scan_ctrl;
  localparam int NDIG = 4;
  localparam int CLK_DIV = 8;
  localparam int BLANK = 2;
  localparam int FRAME = NDIG * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] load_data;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  seg7_scan_ctrl #(.NDIG(NDIG), .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_data(load_data), .dp_in(dp_in),
    .blank_mask(blank_mask), .seg(seg), .dp(dp), .an(an), .pending(pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEGTAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the scan position is simply the number of clocks since reset release
  logic        mvalid = 1'b0;
  int          n;
  logic [15:0] mdisp, msh;
  logic [3:0]  mdp, mshdp;
  logic        mpend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;

  always @(posedge clk) begin
    int q, d, c;
    logic [3:0] onehot;
    logic bnd;
    if (!rst_n) begin
      mvalid = 1'b1; n = 0;
      mdisp = '0; mdp = '0; msh = '0; mshdp = '0; mpend = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else if (mvalid) begin
      q = n % FRAME; d = q / CLK_DIV; c = q % CLK_DIV;
      if (c < BLANK) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        onehot = 4'b0001;
        onehot = onehot << d;
        e_an  = blank_mask[d] ? 4'hF : ~onehot;
        e_seg = SEGTAB[mdisp[4*d +: 4]];
        e_dp  = ~mdp[d];
      end
      bnd = (q == FRAME - 1);
      if (load) begin
        msh = load_data; mshdp = dp_in;
        if (bnd) begin mdisp = load_data; mdp = dp_in; mpend = 1'b0; end
        else mpend = 1'b1;
      end else if (bnd && mpend) begin
        mdisp = msh; mdp = mshdp; mpend = 1'b0;
      end
      n++;
      e_fd = ((n % FRAME) == FRAME - 1);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_an", an, e_an);
      chk("model_seg", seg, e_seg);
      chk("model_dp", dp, e_dp);
      chk("model_pending", pending, mpend);
      chk("model_frame_done", frame_done, e_fd);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] pat, input string name);
    int k = 0;
    do begin tick(); k++; end while (an !== pat && k < 200);
    if (an !== pat) begin
      checks++; failures++;
      $display("FAIL timeout_%s actual_an=%b expected_an=%b", name, an, pat);
    end
  endtask

  task automatic wait_fd(input string name);
    int k = 0;
    do begin tick(); k++; end while (frame_done !== 1'b1 && k < 200);
    if (frame_done !== 1'b1) begin
      checks++; failures++;
      $display("FAIL timeout_%s frame_done=%b expected=1", name, frame_done);
    end
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    load_data = d; dp_in = p; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cnt_dp, cnt_d2, bad;
    rst_n = 1'b0; load = 1'b0; load_data = '0; dp_in = '0; blank_mask = '0;
    // T1 reset and release latency
    repeat (3) tick();
    chk("t1_rst_an", an, 4'hF);
    chk("t1_rst_seg", seg, 7'h7F);
    chk("t1_rst_dp", dp, 1'b1);
    chk("t1_rst_pending", pending, 1'b0);
    rst_n = 1'b1;
    tick(); tick();
    chk("t1_still_blank", an, 4'hF);
    tick();
    chk("t1_first_drive_an", an, 4'b1110);
    chk("t1_first_drive_seg", seg, 7'b0000001);

    // T2 scan of 4321
    pulse_load(16'h4321, 4'b0000);
    chk("t2_pending_set", pending, 1'b1);
    wait_fd("t2_fd");
    tick();
    chk("t2_pending_clr", pending, 1'b0);
    wait_fd("t2_fd2");
    k = 0;
    do begin tick(); k++; end while (frame_done !== 1'b1 && k < 100);
    chk("t2_fd_period", k, 32);
    wait_an(4'b1110, "t2_d0");
    chk("t2_seg_d0", seg, 7'b1001111);
    wait_an(4'b1101, "t2_d1");
    chk("t2_seg_d1", seg, 7'b0010010);

    // T3 atomic update
    wait_an(4'b1101, "t3_d1");
    pulse_load(16'hFFFF, 4'b0000);
    chk("t3_pending", pending, 1'b1);
    wait_an(4'b1011, "t3_d2");
    chk("t3_old_d2", seg, 7'b0000110);
    wait_an(4'b0111, "t3_d3");
    chk("t3_old_d3", seg, 7'b1001100);
    wait_fd("t3_fd");
    chk("t3_pending_at_fd", pending, 1'b1);
    tick();
    chk("t3_pending_after", pending, 1'b0);
    wait_an(4'b1110, "t3_new_d0");
    chk("t3_new_d0", seg, 7'b0111000);
    wait_an(4'b0111, "t3_new_d3");
    chk("t3_new_d3", seg, 7'b0111000);

    // T4 last write wins, then load on the boundary cycle
    wait_an(4'b1110, "t4_d0");
    pulse_load(16'h1111, 4'b0000);
    wait_an(4'b1011, "t4_d2");
    pulse_load(16'h2222, 4'b0000);
    wait_fd("t4_fd");
    tick();
    wait_an(4'b1110, "t4_show_d0");
    chk("t4_last_wins_d0", seg, 7'b0010010);
    wait_an(4'b0111, "t4_show_d3");
    chk("t4_last_wins_d3", seg, 7'b0010010);
    wait_fd("t4_fd2");
    pulse_load(16'h5555, 4'b0000);
    chk("t4_bypass_pending", pending, 1'b0);
    wait_an(4'b1110, "t4_5_d0");
    chk("t4_bypass_seg", seg, 7'b0100100);

    // T5 blank mask and decimal point
    blank_mask = 4'b0100;
    pulse_load(16'h5555, 4'b0001);
    wait_fd("t5_fd");
    tick();
    cnt_dp = 0; cnt_d2 = 0; bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (an === 4'b1011) cnt_d2++;
      if (dp === 1'b0) begin
        cnt_dp++;
        if (an !== 4'b1110) bad++;
      end
    end
    chk("t5_d2_never_lit", cnt_d2, 0);
    chk("t5_dp_low_cycles", cnt_dp, 6);
    chk("t5_dp_only_d0", bad, 0);

    // T6 reset mid-scan with a pending load
    blank_mask = 4'b0000;
    wait_an(4'b1101, "t6_d1");
    pulse_load(16'h9999, 4'b0000);
    chk("t6_pending", pending, 1'b1);
    wait_an(4'b1011, "t6_d2");
    rst_n = 1'b0;
    tick();
    chk("t6_rst_an", an, 4'hF);
    chk("t6_rst_seg", seg, 7'h7F);
    chk("t6_rst_dp", dp, 1'b1);
    chk("t6_rst_pending", pending, 1'b0);
    rst_n = 1'b1;
    tick(); tick();
    chk("t6_restart_blank", an, 4'hF);
    tick();
    chk("t6_restart_an", an, 4'b1110);
    chk("t6_restart_seg", seg, 7'b0000001);
    repeat (FRAME + 8) tick();
    chk("t6_pending_discarded", pending, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
